axis_deadlock_watchdog: RTL
===========================

Name: axis_deadlock_watchdog

Overview:
- Parametrised successor to the fixed 4-channel kernel deadlock monitor used in HLS co-simulation tops.
- Watches N AXI-Stream blocking flags, N matching process-idle flags and M instance-block flags.
- Does not flag a kernel block on the first stalled cycle. It flags one only after a programmable number of consecutive fully-stalled cycles.
- Latches a diagnostic snapshot (stalled channel mask, first offending channel index) and holds it sticky until cleared. Sits beside the kernel instance in the sim top; also synthesizable for on-board debug.

Parameters:
- NUM_AXIS, 4, number of AXIS channels monitored (1..64)
- NUM_INST, 1, number of sub-instance block flags (1..64)
- CNT_W, 16, width of the stall-run counter
- TIMEOUT, 64, consecutive stalled cycles before block is declared (1 .. 2^CNT_W-1)
- IDX_W, 6, width of channel index output (must satisfy 2^IDX_W >= NUM_AXIS)

Ports:
- kernel_monitor_clock  in  1  sole clock
- kernel_monitor_reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of kernel_monitor_clock)
- enable  in  1  1 = monitoring active; 0 = counter held at 0, FSM forced to ARMED (sticky outputs unaffected)
- clear  in  1  one-cycle pulse; clears sticky status and returns FSM to ARMED
- axis_block_sigs  in  NUM_AXIS  1 = channel i blocked on its stream handshake
- inst_idle_sigs  in  NUM_AXIS  1 = process owning channel i is idle
- inst_block_sigs  in  NUM_INST  1 = sub-instance reports internal block
- block  out  1  sticky kernel-block flag
- block_pulse  out  1  single-cycle pulse on the cycle block rises
- blk_mask  out  NUM_AXIS  latched effective-blocked mask at detection
- first_blk_idx  out  IDX_W  lowest index set in blk_mask (0 if only inst_block caused it)
- stall_run  out  CNT_W  current consecutive stalled-cycle count, saturating

Behaviour:
- Reset (kernel_monitor_reset==0 at a clock edge): all outputs 0, stall counter 0, FSM = ARMED. Reset mid-COUNTING or mid-BLOCKED returns to ARMED the same edge.
- Combinational per cycle:
  - eff_blk[i] = axis_block_sigs[i] & ~inst_idle_sigs[i].
  - progressing = any channel with ~axis_block_sigs[i] & ~inst_idle_sigs[i].
  - stalled = ~progressing & (|eff_blk | |inst_block_sigs).
  - All channels idle with no inst_block => not stalled.
- FSM, registered, one transition per clock:
  - ARMED: if enable & stalled -> COUNTING, stall_run=1. If TIMEOUT==1, go directly to BLOCKED instead.
  - COUNTING: if ~stalled or ~enable -> ARMED, stall_run=0. Else stall_run+1. When the incremented value == TIMEOUT -> BLOCKED.
  - BLOCKED: block=1; block_pulse=1 only on the entry cycle; blk_mask and first_blk_idx captured from the same cycle's eff_blk and held. stall_run continues incrementing while stalled, saturating at 2^CNT_W-1; it goes to 0 when not stalled. FSM remains BLOCKED until clear.
- Detection latency: block rises on the edge following the TIMEOUT-th consecutive stalled cycle (TIMEOUT=64 => block visible 64 cycles after first stalled sample).
- clear has priority over detection. clear in the same cycle as the TIMEOUT hit => ARMED, block stays 0, stall_run=0.
- enable=0 does not clear block or the snapshot.
- first_blk_idx: priority encoder, lowest set bit wins.
- Widths: counter compare is unsigned, zero-extended.
- Simulation only (translate_off): on the block rising edge, print "find kernel block." plus the first_blk_idx value, once per detection.

Optional Feature:
- Macro `DLMON_WATERMARK_EN`.
- Defined: extra output stall_max [CNT_W]. It holds the largest stall_run value seen since reset or clear, updated the cycle after stall_run exceeds it, and saturates with stall_run.
- Undefined: port absent and no watermark register.

Test Plan:
- Reset with ch0 stalled, then release reset, TIMEOUT=4, ch0 stalled (block=1, idle=0), others idle -> block and block_pulse rise after exactly 4 stalled cycles; blk_mask=4'b0001, first_blk_idx=0.
- ch1+ch3 stalled 3 cycles, then ch2 progresses (block=0, idle=0) for 1 cycle -> stall_run returns to 0, no block. Restall for 4 cycles -> block with blk_mask=4'b1010, first_blk_idx=1.
- All channels idle, inst_block_sigs=1 for TIMEOUT cycles -> block=1, blk_mask=0, first_blk_idx=0.
- After block, stall persists 2^CNT_W cycles (CNT_W=4) -> stall_run saturates at 15; block_pulse high only once. Pulse clear -> block=0, ARMED. Stall continues -> new detection 4 cycles later.
- clear asserted on the cycle stall_run reaches TIMEOUT -> block stays 0, stall_run=0. enable=0 during stall -> stall_run held 0.
- With DLMON_WATERMARK_EN, stall runs of 3 then 7 cycles (TIMEOUT=16) -> stall_max=7; after clear stall_max=0.

Source files
------------

// File: rtl/axis_deadlock_watchdog.sv
// AXI-Stream kernel deadlock watchdog: flags a block after TIMEOUT stalled cycles.
// Optional stall_max watermark output when DLMON_WATERMARK_EN is defined.
module axis_deadlock_watchdog #(
    parameter int NUM_AXIS = 4,
    parameter int NUM_INST = 1,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 64,
    parameter int IDX_W    = 6
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_AXIS-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block,
    output logic                block_pulse,
    output logic [NUM_AXIS-1:0] blk_mask,
    output logic [IDX_W-1:0]    first_blk_idx,
`ifdef DLMON_WATERMARK_EN
    output logic [CNT_W-1:0]    stall_max,
`endif
    output logic [CNT_W-1:0]    stall_run
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        COUNTING = 2'd1,
        BLOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_run;
    logic [CNT_W-1:0]    w_run_nxt;
    logic [CNT_W-1:0]    w_inc;
    logic [CNT_W-1:0]    w_sat;
    logic                w_hit;
    logic                r_block;
    logic                r_pulse;
    logic [NUM_AXIS-1:0] r_mask;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_AXIS-1:0] w_eff;
    logic                w_prog;
    logic                w_stalled;
    logic [IDX_W-1:0]    w_idx;

    assign w_eff     = axis_block_sigs & ~inst_idle_sigs;
    assign w_prog    = |(~axis_block_sigs & ~inst_idle_sigs);
    assign w_stalled = ~w_prog & ((|w_eff) | (|inst_block_sigs));
    assign w_inc     = r_run + 1'b1;
    assign w_sat     = (r_run == L_MAX) ? r_run : w_inc;

    // Scan downwards so the lowest set channel wins.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (w_eff[i]) w_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_hit       = 1'b0;
        if (clear || !enable) begin
            w_state_nxt = ARMED;
            w_run_nxt   = '0;
        end else begin
            unique case (r_state)
                ARMED: begin
                    w_run_nxt = '0;
                    if (w_stalled) begin
                        w_run_nxt = CNT_W'(1);
                        if (TIMEOUT == 1) begin
                            w_state_nxt = BLOCKED;
                            w_hit       = 1'b1;
                        end else begin
                            w_state_nxt = COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (!w_stalled) begin
                        w_state_nxt = ARMED;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = w_inc;
                        if (w_inc == L_TO) begin
                            w_state_nxt = BLOCKED;
                            w_hit       = 1'b1;
                        end
                    end
                end
                BLOCKED: begin
                    w_run_nxt = w_stalled ? w_sat : '0;
                end
                default: begin
                    w_state_nxt = ARMED;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            r_state <= ARMED;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Snapshot is sticky: a re-entry into BLOCKED without clear keeps the first capture.
    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            r_block <= 1'b0;
            r_pulse <= 1'b0;
            r_mask  <= '0;
            r_idx   <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (clear) begin
                r_block <= 1'b0;
                r_mask  <= '0;
                r_idx   <= '0;
            end else if (w_hit && !r_block) begin
                r_block <= 1'b1;
                r_pulse <= 1'b1;
                r_mask  <= w_eff;
                r_idx   <= w_idx;
            end
        end
    end

`ifdef DLMON_WATERMARK_EN
    logic [CNT_W-1:0] r_max;

    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset || clear) begin
            r_max <= '0;
        end else if (r_run > r_max) begin
            r_max <= r_run;
        end
    end

    assign stall_max = r_max;
`endif

`ifndef SYNTHESIS
    always @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset && r_pulse) begin
            $display("find kernel block. %0d", r_idx);
        end
    end
`endif

    assign block         = r_block;
    assign block_pulse   = r_pulse;
    assign blk_mask      = r_mask;
    assign first_blk_idx = r_idx;
    assign stall_run     = r_run;

endmodule
